// File: rtl/popcount_argmax_seq.sv
// rtl/popcount_argmax_seq.sv - sequential argmax over M captured popcount sums
// Scans a snapshot of the sums one per clock; strict compare keeps the lowest index on ties.
module popcount_argmax_seq #(
  parameter int N = 4,
  parameter int M = 4,
  localparam int SumL = $clog2(N + 1),
  localparam int IdxW = (M > 1) ? $clog2(M) : 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start_i,
  input  logic [M*SumL-1:0]   sums_i,
  output logic                busy_o,
  output logic                done_o,
  output logic [IdxW-1:0]     class_idx_o,
  output logic [SumL-1:0]     max_val_o
);

  typedef enum logic [1:0] {IDLE, SCAN, FIN} state_t;

  localparam logic [IdxW-1:0] LAST_IDX = IdxW'(M - 1);

  state_t              state_q, state_d;
  logic [M*SumL-1:0]   snap_q, snap_d;
  logic [IdxW-1:0]     ptr_q, ptr_d;
  logic [SumL-1:0]     best_val_q, best_val_d;
  logic [IdxW-1:0]     best_idx_q, best_idx_d;
  logic [IdxW-1:0]     class_idx_q, class_idx_d;
  logic [SumL-1:0]     max_val_q, max_val_d;
  logic [SumL-1:0]     cur_val;

  always_comb begin
    cur_val = '0;
    for (int j = 0; j < M; j++) begin
      if (ptr_q == IdxW'(j)) cur_val = snap_q[j*SumL +: SumL];
    end
  end

  always_comb begin
    state_d     = state_q;
    snap_d      = snap_q;
    ptr_d       = ptr_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    class_idx_d = class_idx_q;
    max_val_d   = max_val_q;
    case (state_q)
      IDLE, FIN: begin
        state_d = IDLE;
        if (start_i) begin
          snap_d     = sums_i;
          best_val_d = sums_i[SumL-1:0];
          best_idx_d = '0;
          ptr_d      = IdxW'(1);
          if (M == 1) begin
            state_d     = FIN;
            class_idx_d = '0;
            max_val_d   = sums_i[SumL-1:0];
          end else begin
            state_d = SCAN;
          end
        end
      end
      SCAN: begin
        if (cur_val > best_val_q) begin
          best_val_d = cur_val;
          best_idx_d = ptr_q;
        end
        // The published result includes the final element's comparison.
        if (ptr_q == LAST_IDX) begin
          state_d     = FIN;
          class_idx_d = best_idx_d;
          max_val_d   = best_val_d;
        end else begin
          ptr_d = ptr_q + IdxW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      snap_q      <= '0;
      ptr_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      class_idx_q <= '0;
      max_val_q   <= '0;
    end else begin
      state_q     <= state_d;
      snap_q      <= snap_d;
      ptr_q       <= ptr_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      class_idx_q <= class_idx_d;
      max_val_q   <= max_val_d;
    end
  end

  assign busy_o      = (state_q == SCAN);
  assign done_o      = (state_q == FIN);
  assign class_idx_o = class_idx_q;
  assign max_val_o   = max_val_q;

endmodule

// File: tb/tb_popcount_argmax_seq.sv
// tb/tb_popcount_argmax_seq.sv - directed bench for popcount_argmax_seq
// Three instances: N=4/M=4, N=7/M=1 and N=7/M=10, sharing clock and reset.
module tb_popcount_argmax_seq;

  logic        clk;
  logic        rst;

  logic        a_start;
  logic [11:0] a_sums;
  logic        a_busy, a_done;
  logic [1:0]  a_idx;
  logic [2:0]  a_val;

  logic        b_start;
  logic [2:0]  b_sums;
  logic        b_busy, b_done;
  logic [0:0]  b_idx;
  logic [2:0]  b_val;

  logic        c_start;
  logic [29:0] c_sums;
  logic        c_busy, c_done;
  logic [3:0]  c_idx;
  logic [2:0]  c_val;

  int checks;
  int errors;

  popcount_argmax_seq #(.N(4), .M(4)) dut_a (
    .clk(clk), .rst(rst), .start_i(a_start), .sums_i(a_sums),
    .busy_o(a_busy), .done_o(a_done), .class_idx_o(a_idx), .max_val_o(a_val)
  );

  popcount_argmax_seq #(.N(7), .M(1)) dut_b (
    .clk(clk), .rst(rst), .start_i(b_start), .sums_i(b_sums),
    .busy_o(b_busy), .done_o(b_done), .class_idx_o(b_idx), .max_val_o(b_val)
  );

  popcount_argmax_seq #(.N(7), .M(10)) dut_c (
    .clk(clk), .rst(rst), .start_i(c_start), .sums_i(c_sums),
    .busy_o(c_busy), .done_o(c_done), .class_idx_o(c_idx), .max_val_o(c_val)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Drive a start pulse on instance A; returns in the first cycle after capture.
  task automatic pulse_a(input logic [11:0] s);
    @(negedge clk);
    a_sums  = s;
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    #12;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL reset_flags: busy=%b done=%b, required 0 0", a_busy, a_done);
    end
    checks++;
    if (a_idx !== 2'd0 || a_val !== 3'd0) begin
      errors++;
      $display("FAIL reset_result: idx=%0d val=%0d, required 0 0", a_idx, a_val);
    end
    checks++;
    if (b_done !== 1'b0 || b_val !== 3'd0 || c_busy !== 1'b0 || c_idx !== 4'd0) begin
      errors++;
      $display("FAIL reset_other: b_done=%b b_val=%0d c_busy=%b c_idx=%0d, required 0", b_done, b_val, c_busy, c_idx);
    end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_basic();
    pulse_a({3'd4, 3'd2, 3'd3, 3'd1});
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (a_busy !== 1'b1 || a_done !== 1'b0) begin
        errors++;
        $display("FAIL basic_busy c%0d: busy=%b done=%b, required 1 0", k, a_busy, a_done);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1 || a_busy !== 1'b0 || a_idx !== 2'd3 || a_val !== 3'd4) begin
      errors++;
      $display("FAIL basic_fin: done=%b busy=%b idx=%0d val=%0d, required 1 0 3 4", a_done, a_busy, a_idx, a_val);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b0 || a_idx !== 2'd3 || a_val !== 3'd4) begin
      errors++;
      $display("FAIL basic_hold: done=%b idx=%0d val=%0d, required 0 3 4", a_done, a_idx, a_val);
    end
  endtask

  task automatic test_ties();
    pulse_a({3'd1, 3'd4, 3'd4, 3'd2});
    repeat (3) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd1 || a_val !== 3'd4) begin
      errors++;
      $display("FAIL ties: done=%b idx=%0d val=%0d, required 1 1 4", a_done, a_idx, a_val);
    end
    pulse_a(12'd0);
    repeat (3) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd0 || a_val !== 3'd0) begin
      errors++;
      $display("FAIL all_zero: done=%b idx=%0d val=%0d, required 1 0 0", a_done, a_idx, a_val);
    end
  endtask

  task automatic test_snapshot();
    pulse_a({3'd0, 3'd0, 3'd1, 3'd0});
    a_sums = {3'd4, 3'd4, 3'd4, 3'd4};
    repeat (3) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd1 || a_val !== 3'd1) begin
      errors++;
      $display("FAIL snapshot: done=%b idx=%0d val=%0d, required 1 1 1", a_done, a_idx, a_val);
    end
  endtask

  task automatic test_back_to_back();
    pulse_a({3'd0, 3'd4, 3'd2, 3'd1});
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    checks++;
    if (a_busy !== 1'b1 || a_done !== 1'b0) begin
      errors++;
      $display("FAIL ignored_start: busy=%b done=%b, required 1 0", a_busy, a_done);
    end
    @(negedge clk);
    checks++;
    if (a_busy !== 1'b1 || a_idx !== 2'd1 || a_val !== 3'd1) begin
      errors++;
      $display("FAIL hold_in_scan: busy=%b idx=%0d val=%0d, required 1 1 1", a_busy, a_idx, a_val);
    end
    @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd2 || a_val !== 3'd4) begin
      errors++;
      $display("FAIL b2b_first: done=%b idx=%0d val=%0d, required 1 2 4", a_done, a_idx, a_val);
    end
    a_sums  = {3'd0, 3'd0, 3'd0, 3'd3};
    a_start = 1'b1;
    @(negedge clk);
    a_start = 1'b0;
    for (int k = 1; k <= 3; k++) begin
      checks++;
      if (a_busy !== 1'b1 || a_done !== 1'b0 || a_idx !== 2'd2 || a_val !== 3'd4) begin
        errors++;
        $display("FAIL b2b_scan c%0d: busy=%b done=%b idx=%0d val=%0d, required 1 0 2 4", k, a_busy, a_done, a_idx, a_val);
      end
      @(negedge clk);
    end
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd0 || a_val !== 3'd3) begin
      errors++;
      $display("FAIL b2b_second: done=%b idx=%0d val=%0d, required 1 0 3", a_done, a_idx, a_val);
    end
  endtask

  task automatic test_reset_mid();
    int dones;
    pulse_a({3'd1, 3'd3, 3'd2, 3'd4});
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    checks++;
    if (a_busy !== 1'b0 || a_done !== 1'b0 || a_idx !== 2'd0 || a_val !== 3'd0) begin
      errors++;
      $display("FAIL reset_mid: busy=%b done=%b idx=%0d val=%0d, required 0 0 0 0", a_busy, a_done, a_idx, a_val);
    end
    @(negedge clk);
    rst = 1'b0;
    dones = 0;
    repeat (6) begin
      @(negedge clk);
      if (a_done === 1'b1 || a_busy === 1'b1) dones++;
    end
    checks++;
    if (dones != 0) begin
      errors++;
      $display("FAIL reset_no_done: active cycles=%0d, required 0", dones);
    end
    pulse_a({3'd1, 3'd4, 3'd0, 3'd0});
    repeat (3) @(negedge clk);
    checks++;
    if (a_done !== 1'b1 || a_idx !== 2'd2 || a_val !== 3'd4) begin
      errors++;
      $display("FAIL reset_rerun: done=%b idx=%0d val=%0d, required 1 2 4", a_done, a_idx, a_val);
    end
  endtask

  task automatic test_single_class();
    @(negedge clk);
    b_sums  = 3'd5;
    b_start = 1'b1;
    @(negedge clk);
    b_start = 1'b0;
    checks++;
    if (b_done !== 1'b1 || b_busy !== 1'b0 || b_idx !== 1'b0 || b_val !== 3'd5) begin
      errors++;
      $display("FAIL m1_fin: done=%b busy=%b idx=%0d val=%0d, required 1 0 0 5", b_done, b_busy, b_idx, b_val);
    end
    @(negedge clk);
    checks++;
    if (b_done !== 1'b0 || b_val !== 3'd5) begin
      errors++;
      $display("FAIL m1_after: done=%b val=%0d, required 0 5", b_done, b_val);
    end
  endtask

  task automatic test_wide();
    int busy_cycles;
    @(negedge clk);
    c_sums  = {3'd7, 3'd4, 3'd6, 3'd2, 3'd5, 3'd1, 3'd6, 3'd0, 3'd6, 3'd3};
    c_start = 1'b1;
    @(negedge clk);
    c_start = 1'b0;
    busy_cycles = 0;
    repeat (9) begin
      if (c_busy === 1'b1 && c_done === 1'b0) busy_cycles++;
      @(negedge clk);
    end
    checks++;
    if (busy_cycles != 9) begin
      errors++;
      $display("FAIL m10_busy: busy cycles=%0d, required 9", busy_cycles);
    end
    checks++;
    if (c_done !== 1'b1 || c_idx !== 4'd9 || c_val !== 3'd7) begin
      errors++;
      $display("FAIL m10_fin: done=%b idx=%0d val=%0d, required 1 9 7", c_done, c_idx, c_val);
    end
  endtask

  initial begin
    checks  = 0;
    errors  = 0;
    a_start = 1'b0;
    b_start = 1'b0;
    c_start = 1'b0;
    a_sums  = '0;
    b_sums  = '0;
    c_sums  = '0;
    test_reset();
    test_basic();
    test_ties();
    test_snapshot();
    test_back_to_back();
    test_reset_mid();
    test_single_class();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
